// File: rtl/leg_out_fifo.sv
// leg_out_fifo: output-side buffer behind the LEG core's architectural output port.
// Bytes written with arch_output_enable go into a first-word-fall-through FIFO.
// They leave over a valid/ready handshake. The core cannot be stalled, so the
// FIFO never back-pressures it. A push that arrives while the FIFO is full and
// nothing is popped is dropped, and the loss is recorded in the sticky overflow
// flag.
// Optional build macro LEG_OUT_FIFO_DROPCNT_EN adds a saturating 8-bit count of
// dropped pushes on drop_count. Without it, drop_count is tied to zero.
//
// Occupancy state (implicit in level):
//   state   | meaning
//   EMPTY   | level == 0, nothing to present, out_data forced to zero
//   PARTIAL | 1 <= level <= DEPTH-1, pushes and pops both accepted
//   FULL    | level == DEPTH, a lone push is dropped, push+pop still completes
module leg_out_fifo #(
  parameter int UUID      = 0,
  parameter int DEPTH     = 8,
  parameter int BIT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arch_output_enable,
  input  logic [BIT_WIDTH-1:0]   arch_output_value,
  output logic                   out_valid,
  output logic [BIT_WIDTH-1:0]   out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  input  logic                   clear_overflow,
  output logic [7:0]             drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_ZERO = LW'(0);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  localparam logic [1:0] ST_EMPTY   = 2'b00;
  localparam logic [1:0] ST_PARTIAL = 2'b01;
  localparam logic [1:0] ST_FULL    = 2'b10;

  // Reject parameter values the pointer arithmetic cannot support.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("leg_out_fifo: DEPTH must be a power of two and at least 2");
  end
  if (BIT_WIDTH < 1) begin : g_bad_width
    $error("leg_out_fifo: BIT_WIDTH must be at least 1");
  end
  if (UUID < 0) begin : g_bad_uuid
    $error("leg_out_fifo: UUID must be non-negative");
  end

  logic [BIT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        level_q;
  logic                 overflow_q;
  logic [1:0]           state;

  logic push;
  logic pop;
  logic wr_en;
  logic drop;

  // Decode the occupancy state from the registered level counter.
  always_comb begin
    state = ST_PARTIAL;
    if (level_q == LVL_ZERO) begin
      state = ST_EMPTY;
    end else if (level_q == LVL_FULL) begin
      state = ST_FULL;
    end
  end

  assign empty     = (state == ST_EMPTY);
  assign full      = (state == ST_FULL);
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign out_valid = !empty;

  // A pop frees the head slot in the same edge, so a push into a full FIFO
  // still completes when the consumer takes the head at the same time.
  assign push  = arch_output_enable;
  assign pop   = out_valid && out_ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  // Head entry is read combinationally and zeroed while nothing is buffered.
  assign out_data = out_valid ? mem[rd_ptr] : '0;

  // Storage array, deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= arch_output_value;
    end
  end

  // Write pointer advances on every accepted push and wraps modulo DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  // Read pointer advances on every pop and wraps modulo DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Occupancy counter is kept separately from the pointers. A simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= '0;
    end else begin
      case ({wr_en, pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  // Sticky loss flag. If a drop and a clear happen in the same cycle, the drop wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (clear_overflow) begin
      overflow_q <= 1'b0;
    end
  end

`ifdef LEG_OUT_FIFO_DROPCNT_EN
  logic [7:0] drop_cnt_q;

  // Saturating drop counter. A clear in the same cycle as a drop restarts the count at 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= 8'd0;
    end else if (drop) begin
      if (clear_overflow) begin
        drop_cnt_q <= 8'd1;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end else if (clear_overflow) begin
      drop_cnt_q <= 8'd0;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_leg_out_fifo.sv
// Directed bench for leg_out_fifo (DEPTH=8, BIT_WIDTH=8).
// Drop-count expectations follow the LEG_OUT_FIFO_DROPCNT_EN build macro.
module tb_leg_out_fifo;

  logic       clk;
  logic       rst;
  logic       arch_output_enable;
  logic [7:0] arch_output_value;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [3:0] level;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       clear_overflow;
  logic [7:0] drop_count;

  int total;
  int bad;

  leg_out_fifo #(.UUID(0), .DEPTH(8), .BIT_WIDTH(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .arch_output_enable (arch_output_enable),
    .arch_output_value  (arch_output_value),
    .out_valid          (out_valid),
    .out_data           (out_data),
    .out_ready          (out_ready),
    .level              (level),
    .full               (full),
    .empty              (empty),
    .overflow           (overflow),
    .clear_overflow     (clear_overflow),
    .drop_count         (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_drops(input logic [7:0] n);
`ifdef LEG_OUT_FIFO_DROPCNT_EN
    return n;
`else
    return 8'd0;
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    arch_output_enable = 1'b0;
    arch_output_value = 8'h00;
    out_ready = 1'b0;
    clear_overflow = 1'b0;
    step();
    step();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", out_data); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
    #2 rst = 1'b1;
    step();
  endtask

  task automatic test_order();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      arch_output_enable = 1'b1;
      arch_output_value = vals[i];
      step();
    end
    arch_output_enable = 1'b0;
    total++; if (level !== 4'd3) begin bad++; $display("FAIL order_level got=%0d exp=3", level); end
    total++; if (out_data !== 8'h11) begin bad++; $display("FAIL order_head got=%h exp=11", out_data); end
    step();
    total++; if (out_data !== 8'h11) begin bad++; $display("FAIL order_hold got=%h exp=11", out_data); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== vals[i]) begin
        bad++; $display("FAIL order_pop%0d got=%b/%h exp=1/%h", i, out_valid, out_data, vals[i]);
      end
      step();
    end
    out_ready = 1'b0;
    total++; if (empty !== 1'b1 || out_data !== 8'h00) begin bad++; $display("FAIL order_empty got=%b/%h exp=1/00", empty, out_data); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 10; i++) begin
      arch_output_enable = 1'b1;
      arch_output_value = (i < 8) ? 8'(i) : ((i == 8) ? 8'hAA : 8'hBB);
      step();
    end
    arch_output_enable = 1'b0;
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", full); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fill_ovf got=%b exp=1", overflow); end
    total++; if (level !== 4'd8) begin bad++; $display("FAIL fill_level got=%0d exp=8", level); end
    total++; if (drop_count !== exp_drops(8'd2)) begin bad++; $display("FAIL fill_drop got=%0d exp=%0d", drop_count, exp_drops(8'd2)); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (out_data !== 8'(i)) begin bad++; $display("FAIL fill_drain%0d got=%h exp=%h", i, out_data, 8'(i)); end
      step();
    end
    out_ready = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL fill_drained got=%b exp=1", empty); end
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    total++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin bad++; $display("FAIL fill_clear got=%b/%0d exp=0/0", overflow, drop_count); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) begin
      arch_output_enable = 1'b1;
      arch_output_value = 8'(i);
      step();
    end
    arch_output_value = 8'hC0;
    out_ready = 1'b1;
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL fpp_head got=%h exp=00", out_data); end
    step();
    arch_output_enable = 1'b0;
    total++; if (level !== 4'd8) begin bad++; $display("FAIL fpp_level got=%0d exp=8", level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_ovf got=%b exp=0", overflow); end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] e;
      e = (i < 7) ? 8'(i + 1) : 8'hC0;
      total++;
      if (out_data !== e) begin bad++; $display("FAIL fpp_drain%0d got=%h exp=%h", i, out_data, e); end
      step();
    end
    out_ready = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL fpp_empty got=%b exp=1", empty); end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      arch_output_enable = 1'b1;
      arch_output_value = 8'(i);
      step();
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'(i) || level !== 4'd1) begin
        bad++; $display("FAIL wrap%0d got=%b/%h/%0d exp=1/%h/1", i, out_valid, out_data, level, 8'(i));
      end
    end
    arch_output_enable = 1'b0;
    step();
    out_ready = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", empty); end
  endtask

  task automatic test_clear_vs_drop();
    for (int i = 0; i < 8; i++) begin
      arch_output_enable = 1'b1;
      arch_output_value = 8'hE0 + 8'(i);
      step();
    end
    arch_output_value = 8'hDD;
    clear_overflow = 1'b1;
    step();
    arch_output_enable = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL cvd_ovf got=%b exp=1", overflow); end
    total++; if (drop_count !== exp_drops(8'd1)) begin bad++; $display("FAIL cvd_drop got=%0d exp=%0d", drop_count, exp_drops(8'd1)); end
    step();
    clear_overflow = 1'b0;
    total++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin bad++; $display("FAIL cvd_clear got=%b/%0d exp=0/0", overflow, drop_count); end
    total++; if (level !== 4'd8 || out_data !== 8'hE0) begin bad++; $display("FAIL cvd_keep got=%0d/%h exp=8/E0", level, out_data); end
  endtask

  task automatic test_drop_saturate();
    arch_output_enable = 1'b1;
    arch_output_value = 8'h77;
    for (int i = 0; i < 260; i++) step();
    arch_output_enable = 1'b0;
    total++; if (drop_count !== exp_drops(8'd255)) begin bad++; $display("FAIL sat_drop got=%0d exp=%0d", drop_count, exp_drops(8'd255)); end
    total++; if (level !== 4'd8 || out_data !== 8'hE0) begin bad++; $display("FAIL sat_keep got=%0d/%h exp=8/E0", level, out_data); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    out_ready = 1'b0;
    total++; if (level !== 4'd5 || out_data !== 8'hE3 || overflow !== 1'b1) begin
      bad++; $display("FAIL ares_pre got=%0d/%h/%b exp=5/E3/1", level, out_data, overflow);
    end
    #2 rst = 1'b0;
    #1;
    total++; if (level !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL ares_level got=%0d/%b/%b exp=0/1/0", level, empty, full); end
    total++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin bad++; $display("FAIL ares_out got=%b/%h exp=0/00", out_valid, out_data); end
    total++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin bad++; $display("FAIL ares_ovf got=%b/%0d exp=0/0", overflow, drop_count); end
    #3 rst = 1'b1;
    step();
    arch_output_enable = 1'b1;
    arch_output_value = 8'h5A;
    step();
    arch_output_enable = 1'b0;
    total++; if (level !== 4'd1 || out_data !== 8'h5A) begin bad++; $display("FAIL ares_after got=%0d/%h exp=1/5A", level, out_data); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_order();
    test_fill_overflow();
    test_full_push_pop();
    test_wrap();
    test_clear_vs_drop();
    test_drop_saturate();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/leg_out_fifo.md
# leg_out_fifo

Output-side buffer for the LEG core. It sits directly downstream of the core's architectural output port. It captures every byte the core writes with `arch_output_enable` into a first-word-fall-through FIFO, then hands the bytes to an external consumer over a valid/ready handshake. The core has no stall path, so this block never back-pressures it: on overflow it drops the byte, records the loss, and keeps running.

## Interface
Parameters:
- `UUID`, 0, instance identifier; has no functional effect.
- `DEPTH`, 8, number of FIFO entries; a power of two, minimum 2.
- `BIT_WIDTH`, 8, data width; must match the core's output width.

Ports:
- `clk`  in  1  the only clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `arch_output_enable`  in  1  push strobe from the core, one byte per high cycle.
- `arch_output_value`  in  BIT_WIDTH  byte pushed when the strobe is high.
- `out_valid`  out  1  head entry is available.
- `out_data`  out  BIT_WIDTH  head entry; zero when `out_valid`=0.
- `out_ready`  in  1  consumer accepts the head entry.
- `level`  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `full`  out  1  `level`==DEPTH.
- `empty`  out  1  `level`==0.
- `overflow`  out  1  sticky flag: at least one push was dropped.
- `clear_overflow`  in  1  clears `overflow` (and `drop_count` when compiled in).
- `drop_count`  out  8  saturating count of dropped pushes; see Configuration.

## Operation
- Storage is a DEPTH-entry register array with write and read pointers of clog2(DEPTH) bits each. Both pointers wrap naturally modulo DEPTH.
- `level` is a separate registered counter, not derived from the pointers.
- Push event: `arch_output_enable`=1. Pop event: `out_valid`=1 and `out_ready`=1.
- Occupancy after each cycle:
  - Push and no pop: if not full, write the byte at the write pointer, advance it, `level`+1; if full, drop the byte (see overflow).
  - Pop and no push: advance the read pointer, `level`-1.
  - Push and pop together: both complete, including when full; `level` is unchanged and nothing is dropped.
- Overflow: a push while full with no pop discards the byte. Pointers and `level` are unchanged; `overflow` is set.
- Clearing: `clear_overflow`=1 clears `overflow` on the next edge. If a drop happens in the same cycle, set wins and `overflow` stays 1.
- There is no bypass path. A push into an empty FIFO is not visible until the next cycle, even if `out_ready` is high.
- `out_data` is the combinational read of the head entry, gated by `out_valid`. `out_valid` = !`empty`.
- State machine: implicit in `level`, with three states: EMPTY (0), PARTIAL (1..DEPTH-1) and FULL (DEPTH). The transitions are exactly those listed under occupancy; there are no other states.

## Timing
- Reset (`rst` low, asynchronous) forces:
  - pointers and `level` = 0;
  - `empty`=1; `full`=0; `out_valid`=0; `out_data`=0;
  - `overflow`=0; `drop_count`=0.
- The storage array is not reset.
- Reset asserted mid-stream discards all buffered bytes immediately.
- Release of reset is taken synchronously at the next edge.
- Latency from push to visibility: a push at edge N makes `out_valid`=1 and `out_data` valid after edge N (one cycle).
- Throughput: one push and one pop per cycle, sustained, at any occupancy.
- `level`, `full`, `empty` and `overflow` are registered and reflect the state after the last edge.
- The consumer may hold `out_ready` high permanently. `out_data` must not change while `out_valid`=1 and `out_ready`=0.

## Configuration
- Macro: `LEG_OUT_FIFO_DROPCNT_EN`.
- Defined:
  - `drop_count` is an 8-bit register, incremented on each dropped push and saturating at 255.
  - It is cleared by `clear_overflow` unless a drop occurs in the same cycle; in that case it loads 1.
  - It resets to 0.
- Undefined: `drop_count` is tied to 0 and no counter logic exists. `overflow` behaves identically in both builds.

## Test plan
- Basic order: after reset, push 0x11,0x22,0x33 on consecutive cycles with `out_ready`=0. Then `level`=3 and `out_data`=0x11. Raising `out_ready` pops 0x11,0x22,0x33 on consecutive cycles, then `empty`=1 and `out_data`=0.
- Fill/overflow, DEPTH=8:
  - Push 0x00..0x07, then 0xAA,0xBB with `out_ready`=0. Then `full`=1, `overflow`=1, `drop_count`=2 (with the macro) and `level`=8.
  - Draining yields 0x00..0x07 only.
- Full with simultaneous push and pop: fill with 0x00..0x07, then push 0xC0 with `out_ready`=1. 0x00 is popped, 0xC0 is accepted as the 8th entry, `level` stays 8 and `overflow` stays 0.
- Wrap-around: stream 20 bytes 0x01..0x14 with `out_ready`=1 throughout. The output is in order with exactly one cycle of latency, and `level` never exceeds 1.
- Clear vs. drop: while full, assert `clear_overflow` and a dropping push in the same cycle. Then `overflow`=1 and `drop_count`=1. Asserting `clear_overflow` alone next cycle gives `overflow`=0 and `drop_count`=0.
- Async reset: with `level`=5, pulse `rst` low between edges. Outputs go to their reset values immediately, without waiting for a clock edge.
